// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared widths, reset PC, PC step and fetch FSM states
package instr_fetch_unit_pkg;
   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0100_0000;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;
   typedef enum logic {RUN, DRAIN} fetch_state_e;
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries with flush and occupancy count
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   assign empty = count == '0;
   assign rdata = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited in-order instruction fetch with redirect and stale-response drop
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   fetch_state_e state, state_next;
   logic [XLEN-1:0] fetch_pc, rsp_pc, fetch_pc_next, rsp_pc_next;
   logic [CW-1:0] outstanding, drop_cnt, outstanding_next, drop_cnt_next, fifo_count;
   logic fire, push, pop, empty;
   logic [XLEN+ILEN-1:0] head;
   // A request is only issued if its response is guaranteed a buffer slot
   assign imem_req_valid = !rst && !redirect_valid && (32'(outstanding) + 32'(fifo_count) < FIFO_DEPTH);
   assign imem_req_addr = fetch_pc;
   assign fire = imem_req_valid && imem_req_ready;
   assign push = imem_rsp_valid && !redirect_valid && state == RUN;
   assign id_valid = !empty && !redirect_valid;
   assign pop = id_valid && id_ready;
   assign {id_pc, id_instr} = head;
   always_comb begin
      outstanding_next = outstanding + CW'(fire) - CW'(imem_rsp_valid);
      drop_cnt_next = redirect_valid ? outstanding - CW'(imem_rsp_valid)
                                     : drop_cnt - CW'(imem_rsp_valid && state == DRAIN);
      state_next = drop_cnt_next != '0 ? DRAIN : RUN;
      fetch_pc_next = redirect_valid ? align_pc(redirect_pc) : fire ? fetch_pc + PC_STEP : fetch_pc;
      rsp_pc_next = redirect_valid ? align_pc(redirect_pc) : push ? rsp_pc + PC_STEP : rsp_pc;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_next;
         fetch_pc    <= fetch_pc_next;
         rsp_pc      <= rsp_pc_next;
         outstanding <= outstanding_next;
         drop_cnt    <= drop_cnt_next;
      end
   end
   fetch_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .flush(redirect_valid),
      .push(push),
      .wdata({rsp_pc, imem_rsp_data}),
      .pop(pop),
      .rdata(head),
      .count(fifo_count),
      .empty(empty)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench with an epoch-tagged memory model and expected decode queue
module tb_instr_fetch_unit;
   localparam int DEPTH = 4;
   localparam logic [31:0] RPC = 32'h0100_0000;
   logic clk = 0;
   always #5 clk = ~clk;
   logic rst, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, id_valid, id_ready;
   logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, id_instr, id_pc;
   instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
   );
   typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
   req_t mq[$];
   logic [63:0] fq[$];
   logic [31:0] fired[$];
   int cyc = 0, epoch = 0, vectors = 0, miscompares = 0;
   logic [31:0] next_addr;
   int rdy_pct = 100, idr_pct = 100, lat_lo = 1, lat_hi = 1, redir_pct = 0, rst_pm = 0;
   logic force_rst = 0, force_redir = 0;
   logic [31:0] force_pc = 0;
   logic s_rv, s_idv;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock: drive at negedge, compare against the model, advance the model at posedge
   task automatic step();
      logic exp_rv, exp_idv, fire, pop, keep;
      req_t r;
      @(negedge clk);
      rst = force_rst || ($urandom_range(999) < rst_pm);
      redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
      redirect_pc = force_redir ? force_pc
                  : ($urandom_range(3) == 0 ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom);
      imem_req_ready = $urandom_range(99) < rdy_pct;
      id_ready = $urandom_range(99) < idr_pct;
      imem_rsp_valid = !rst && mq.size() > 0 && mq[0].due <= cyc;
      imem_rsp_data = imem_rsp_valid ? mem_word(mq[0].addr) : $urandom;
      #1;
      exp_rv = !rst && !redirect_valid && (mq.size() + fq.size() < DEPTH);
      exp_idv = fq.size() > 0 && !redirect_valid;
      s_rv = imem_req_valid; s_addr = imem_req_addr; s_idv = id_valid; s_pc = id_pc; s_instr = id_instr;
      chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("imem_req_addr", imem_req_addr, next_addr);
      chk("id_valid", 32'(id_valid), 32'(exp_idv));
      if (exp_idv) begin
         chk("id_pc", id_pc, fq[0][63:32]);
         chk("id_instr", id_instr, fq[0][31:0]);
      end else if (fq.size() == 0) begin
         chk("id_pc_empty", id_pc, 32'd0);
         chk("id_instr_empty", id_instr, 32'd0);
      end
      fire = exp_rv && imem_req_ready;
      pop = exp_idv && id_ready;
      if (imem_req_valid && imem_req_ready) fired.push_back(imem_req_addr);
      @(posedge clk);
      if (rst) begin
         mq.delete(); fq.delete(); epoch++; next_addr = RPC;
      end else begin
         keep = 0;
         if (imem_rsp_valid) begin
            r = mq.pop_front();
            keep = !redirect_valid && r.epoch == epoch;
         end
         if (redirect_valid) begin
            fq.delete(); epoch++; next_addr = {redirect_pc[31:2], 2'b00};
         end else begin
            if (pop) void'(fq.pop_front());
            if (keep) fq.push_back({r.addr, mem_word(r.addr)});
            if (fire) begin
               mq.push_back('{next_addr, epoch, cyc + int'($urandom_range(lat_hi, lat_lo))});
               next_addr += 32'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      force_rst = 1; step(); step(); force_rst = 0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      force_redir = 1; force_pc = pc; step(); force_redir = 0;
   endtask

   task automatic wait_idv(input string name);
      int n = 0;
      while (!s_idv && n < 60) begin step(); n++; end
      if (!s_idv) begin miscompares++; vectors++; $display("FAIL %s timeout: got no id_valid expected id_valid", name); end
   endtask

   initial begin
      rst = 1; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
      imem_rsp_valid = 0; imem_rsp_data = 0; id_ready = 0;
      repeat (2) @(posedge clk);
      next_addr = RPC;
      // Sequential fetch, latency 1, decode always ready
      do_reset();
      step(); chk("p1_addr0", s_addr, 32'h0100_0000); chk("p1_idv0", 32'(s_idv), 32'd0);
      step(); chk("p1_addr1", s_addr, 32'h0100_0004);
      step(); chk("p1_addr2", s_addr, 32'h0100_0008); chk("p1_idv2", 32'(s_idv), 32'd1);
      chk("p1_pc2", s_pc, 32'h0100_0000); chk("p1_instr2", s_instr, 32'h0000_0113);
      repeat (20) step();
      // Decode stalled: buffer fills, requests stop, then drain resumes at +0x10
      do_reset();
      idr_pct = 0;
      repeat (8) step();
      chk("p2_rv_full", 32'(s_rv), 32'd0); chk("p2_idv_full", 32'(s_idv), 32'd1);
      chk("p2_head", s_pc, 32'h0100_0000);
      idr_pct = 100;
      step(); step();
      chk("p2_resume_rv", 32'(s_rv), 32'd1); chk("p2_resume_addr", s_addr, 32'h0100_0010);
      chk("p2_pc", s_pc, 32'h0100_0004);
      repeat (10) step();
      // Redirect with two requests in flight
      do_reset();
      lat_lo = 3; lat_hi = 3;
      step(); step();
      redirect_to(32'h0000_0200);
      step();
      chk("p3_idv_after", 32'(s_idv), 32'd0); chk("p3_addr", s_addr, 32'h0000_0200);
      wait_idv("p3_wait");
      chk("p3_first_pc", s_pc, 32'h0000_0200);
      // Misaligned redirect while streaming (response usually same cycle)
      lat_lo = 1; lat_hi = 1;
      repeat (5) step();
      redirect_to(32'h0000_0203);
      chk("p4_idv_redirect", 32'(s_idv), 32'd0);
      step();
      chk("p4_rv", 32'(s_rv), 32'd1); chk("p4_addr", s_addr, 32'h0000_0200);
      repeat (10) step();
      // Address wrap with random request stalls
      rdy_pct = 50;
      redirect_to(32'hFFFF_FFF8);
      fired.delete();
      for (int i = 0; i < 100 && fired.size() < 3; i++) step();
      if (fired.size() < 3) begin miscompares++; vectors++; $display("FAIL p5_fires: got %0d expected 3", fired.size()); end
      else begin
         chk("p5_a0", fired[0], 32'hFFFF_FFF8); chk("p5_a1", fired[1], 32'hFFFF_FFFC); chk("p5_a2", fired[2], 32'h0000_0000);
      end
      repeat (20) step();
      // Reset mid-operation
      rdy_pct = 100; idr_pct = 0; lat_lo = 3; lat_hi = 3;
      repeat (5) step();
      do_reset();
      chk("p6_rv_rst", 32'(s_rv), 32'd0); chk("p6_idv_rst", 32'(s_idv), 32'd0);
      idr_pct = 100;
      step();
      chk("p6_rv", 32'(s_rv), 32'd1); chk("p6_addr", s_addr, 32'h0100_0000);
      wait_idv("p6_wait");
      chk("p6_pc", s_pc, 32'h0100_0000);
      // Random traffic
      lat_lo = 1; lat_hi = 5; rdy_pct = 70; idr_pct = 60; redir_pct = 3; rst_pm = 3;
      repeat (3000) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
